// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl
// Timekeeping and time-set controller for the digital clock. A free-running
// divider produces a one-second tick that advances a cascaded BCD
// hh:mm:ss counter chain while in RUN. A three-state FSM (RUN -> SET_HOUR ->
// SET_MIN -> RUN) pauses timekeeping so hours and minutes can be adjusted
// with the increment button.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   mode_btn   one-cycle pulse, advances the FSM
//   inc_btn    one-cycle pulse, increments the selected field in set states
//   sec_lo/hi  BCD seconds units / tens
//   min_lo/hi  BCD minutes units / tens
//   hr_lo/hi   BCD hours units / tens
//   state      0=RUN, 1=SET_HOUR, 2=SET_MIN
//   blink      blank request for the field being edited (second half of each second)
//   sec_pulse  one-cycle pulse in the cycle after the time advances in RUN

module clock_time_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] hr_lo,
   output logic [3:0] hr_hi,
   output logic [1:0] state,
   output logic       blink,
   output logic       sec_pulse
);

   localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_t;

   state_t          st;
   logic [DW-1:0]   div_cnt;
   logic            tick;

   logic [3:0] sec_lo_nx, sec_hi_nx, min_lo_nx, min_hi_nx, hr_lo_nx, hr_hi_nx;
   logic       sec_wrap, min_wrap, hr_wrap;

   assign state = st;
   assign tick  = (div_cnt == DW'(TICK_DIV - 1));
   assign blink = (st != RUN) && (div_cnt >= DW'(TICK_DIV / 2));

   // Incremented value of each field on its own; cascading is decided by the
   // wrap flags in the sequential block. Comparisons use >= so a digit can
   // never climb past its range.
   always_comb begin
      sec_wrap  = (sec_lo >= 4'd9) && (sec_hi >= 4'd5);
      sec_lo_nx = (sec_lo >= 4'd9) ? 4'd0 : sec_lo + 4'd1;
      sec_hi_nx = sec_hi;
      if (sec_lo >= 4'd9)
         sec_hi_nx = (sec_hi >= 4'd5) ? 4'd0 : sec_hi + 4'd1;

      min_wrap  = (min_lo >= 4'd9) && (min_hi >= 4'd5);
      min_lo_nx = (min_lo >= 4'd9) ? 4'd0 : min_lo + 4'd1;
      min_hi_nx = min_hi;
      if (min_lo >= 4'd9)
         min_hi_nx = (min_hi >= 4'd5) ? 4'd0 : min_hi + 4'd1;

      // 23 -> 00 takes priority over the ordinary units-digit carry
      hr_wrap  = (hr_hi >= 4'd2) && (hr_lo >= 4'd3);
      hr_lo_nx = 4'd0;
      hr_hi_nx = 4'd0;
      if (!hr_wrap) begin
         hr_lo_nx = (hr_lo >= 4'd9) ? 4'd0 : hr_lo + 4'd1;
         hr_hi_nx = (hr_lo >= 4'd9) ? hr_hi + 4'd1 : hr_hi;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= RUN;
         div_cnt   <= '0;
         sec_lo    <= 4'd0;
         sec_hi    <= 4'd0;
         min_lo    <= 4'd0;
         min_hi    <= 4'd0;
         hr_lo     <= 4'd0;
         hr_hi     <= 4'd0;
         sec_pulse <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         div_cnt   <= tick ? '0 : div_cnt + DW'(1);

         case (st)
            RUN: begin
               // mode_btn beats a coincident tick: time does not advance
               if (mode_btn) begin
                  st <= SET_HOUR;
               end else if (tick) begin
                  sec_pulse <= 1'b1;
                  sec_lo    <= sec_lo_nx;
                  sec_hi    <= sec_hi_nx;
                  if (sec_wrap) begin
                     min_lo <= min_lo_nx;
                     min_hi <= min_hi_nx;
                  end
                  if (sec_wrap && min_wrap) begin
                     hr_lo <= hr_lo_nx;
                     hr_hi <= hr_hi_nx;
                  end
               end
            end
            SET_HOUR: begin
               if (mode_btn) begin
                  st <= SET_MIN;
               end else if (inc_btn) begin
                  hr_lo <= hr_lo_nx;
                  hr_hi <= hr_hi_nx;
               end
            end
            SET_MIN: begin
               if (mode_btn) begin
                  // restart the second cleanly so a full second passes first
                  st      <= RUN;
                  sec_lo  <= 4'd0;
                  sec_hi  <= 4'd0;
                  div_cnt <= '0;
               end else if (inc_btn) begin
                  // minutes wrap 59 -> 00 without touching hours
                  min_lo <= min_lo_nx;
                  min_hi <= min_hi_nx;
               end
            end
            default: st <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICK_DIV=4.
module tb_clock_time_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
   logic [1:0] state;
   logic       blink, sec_pulse;

   int checks = 0;
   int errors = 0;

   clock_time_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
      .hr_lo(hr_lo), .hr_hi(hr_hi), .state(state), .blink(blink),
      .sec_pulse(sec_pulse)
   );

   always #5 clk = ~clk;

   logic [23:0] tm;
   assign tm = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_inc(input int n);
      inc_btn = 1'b1;
      repeat (n) step();
      inc_btn = 1'b0;
   endtask

   task automatic press_mode();
      mode_btn = 1'b1;
      step();
      mode_btn = 1'b0;
   endtask

   int pulses;
   int wide;
   logic prev_pulse;

   initial begin
      // reset state
      #1 rst = 1'b1;
      #1;
      chk("reset_time", tm, 24'h000000);
      chk("reset_state", 24'(state), 24'd0);
      chk("reset_blink", 24'(blink), 24'd0);
      chk("reset_pulse", 24'(sec_pulse), 24'd0);
      #10 rst = 1'b0;   // released at t=12, first edge at t=15

      // 40 cycles of RUN
      pulses = 0;
      wide = 0;
      prev_pulse = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (sec_pulse) pulses++;
         if (sec_pulse && prev_pulse) wide++;
         prev_pulse = sec_pulse;
         if (i == 2)  chk("no_adv_edge3", tm, 24'h000000);
         if (i == 3)  chk("first_adv_edge4", tm, 24'h000001);
         if (i == 38) chk("edge39", tm, 24'h000009);
         if (i == 39) chk("edge40_carry", tm, 24'h000010);
      end
      chk("pulse_count", 24'(pulses), 24'd10);
      chk("pulse_width", 24'(wide), 24'd0);

      // set 23:59 through the buttons
      press_mode();
      chk("to_set_hour", 24'(state), 24'd1);
      press_inc(23);
      chk("hours_23", tm, 24'h230010);
      press_mode();
      chk("to_set_min", 24'(state), 24'd2);
      press_inc(59);
      chk("min_59", tm, 24'h235910);
      press_inc(1);
      chk("min_wrap_no_carry", tm, 24'h230010);
      press_inc(59);
      press_mode();
      chk("back_to_run", 24'(state), 24'd0);
      chk("set_time", tm, 24'h235900);

      // 240 cycles = 60 seconds -> midnight rollover
      for (int i = 0; i < 240; i++) begin
         step();
         if (i == 235) chk("pre_midnight", tm, 24'h235959);
      end
      chk("midnight", tm, 24'h000000);

      // mode coincident with a tick: tick discarded
      step(); step(); step();          // divider now at its last count
      chk("pre_tick_time", tm, 24'h000000);
      press_mode();
      chk("mode_on_tick_state", 24'(state), 24'd1);
      chk("mode_on_tick_time", tm, 24'h000000);
      chk("mode_on_tick_pulse", 24'(sec_pulse), 24'd0);

      // SET_HOUR: blink 0,0,1,1 and frozen time
      chk("blink_div0", 24'(blink), 24'd0);
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("blink_pattern", 24'(blink), 24'((i % 4) >= 2));
         if (sec_pulse) chk("frozen_pulse", 24'(sec_pulse), 24'd0);
      end
      chk("frozen_time", tm, 24'h000000);

      // hours 23 -> 00 in SET_HOUR
      press_inc(23);
      chk("set_hr_23", tm, 24'h230000);
      press_inc(1);
      chk("set_hr_wrap", tm, 24'h000000);

      // mode + inc together: mode wins
      press_inc(12);
      mode_btn = 1'b1;
      inc_btn  = 1'b1;
      step();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      chk("both_state", 24'(state), 24'd2);
      chk("both_hours", tm, 24'h120000);
      press_inc(34);
      chk("time_1234", tm, 24'h123400);

      // async reset between edges
      #2 rst = 1'b1;
      #1;
      chk("async_rst_time", tm, 24'h000000);
      chk("async_rst_state", 24'(state), 24'd0);
      chk("async_rst_blink", 24'(blink), 24'd0);
      #1 rst = 1'b0;

      // inc ignored in RUN, blink stays low
      press_inc(1);
      chk("run_inc_ignored", tm, 24'h000000);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("run_blink", 24'(blink), 24'd0);
      end
      chk("run_after_reset", tm, 24'h000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
